// File: rtl/gemm_pkg.sv
// Shared types, default parameters and arithmetic helpers for the streaming GEMM engine.
package gemm_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_MATRIX_DIM = 4;
    localparam int DEF_ACC_WIDTH  = 48;

    // Signed working width of the finalize path; must cover ACC_WIDTH and 2*DATA_WIDTH+1.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic [SAT_W-1:0] val;
        logic             hit;
    } sat_t;

    // Index width for a counter addressing n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Clamp x to the signed dw-bit range; hit flags that a clamp was applied.
    function automatic sat_t sat_dw(input logic signed [SAT_W-1:0] x, input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (dw - 1));
        r.val = x;
        r.hit = 1'b0;
        if (x > hi) begin
            r.val = hi;
            r.hit = 1'b1;
        end else if (x < lo) begin
            r.val = lo;
            r.hit = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gemm_mac.sv
// Single time-shared multiply-accumulator plus the alpha/beta finalize and saturation datapath.
module gemm_mac
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  finalize,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  sat
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [SAT_W-1:0]        p_wide;
    logic signed [SAT_W-1:0]        t_wide;
    sat_t                           p_sat;
    sat_t                           r_sat;
    logic                           unused_hi;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = ACC_WIDTH'(prod);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= (clear ? '0 : acc_q) + prod_ext;
        end
    end

    // Both products fit in 2*DATA_WIDTH+1 bits, so the wide sum never wraps.
    always_comb begin
        p_wide    = SAT_W'(acc_q) >>> FRAC_BITS;
        p_sat     = sat_dw(p_wide, DATA_WIDTH);
        t_wide    = SAT_W'($signed(alpha)) * $signed(p_sat.val)
                  + SAT_W'($signed(beta)) * SAT_W'($signed(c));
        r_sat     = sat_dw(t_wide >>> FRAC_BITS, DATA_WIDTH);
        result    = r_sat.val[DATA_WIDTH-1:0];
        sat       = finalize & (p_sat.hit | r_sat.hit);
        unused_hi = ^r_sat.val[SAT_W-1:DATA_WIDTH];
    end

endmodule

// File: rtl/gemm_stream_engine.sv
// Streaming GEMM engine: loads A, B, C over a handshake, computes alpha*(A*B)+beta*C with one MAC, streams R out.
module gemm_stream_engine
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int MATRIX_DIM = DEF_MATRIX_DIM,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  ovf
);

    localparam int NN = MATRIX_DIM * MATRIX_DIM;
    localparam int IW = idx_w(MATRIX_DIM);
    localparam int KW = idx_w(MATRIX_DIM + 1);
    localparam int EW = idx_w(NN);
    localparam int LW = idx_w(3 * NN);

    state_t                state_q, state_d;
    logic [LW-1:0]         load_cnt;
    logic [IW-1:0]         i_cnt, j_cnt;
    logic [KW-1:0]         k_cnt, k_rd;
    logic [EW-1:0]         out_idx, ld_idx, a_idx, b_idx, c_idx;
    logic [1:0]            ld_sel;
    logic [DATA_WIDTH-1:0] alpha_q, beta_q, mac_result;
    logic                  in_fire, out_fire, load_last, out_last;
    logic                  is_comp, k_fin, j_last, i_last, comp_last;
    logic                  mac_en, mac_fin, mac_clr, mac_sat;

    logic [DATA_WIDTH-1:0] a_mem [NN];
    logic [DATA_WIDTH-1:0] b_mem [NN];
    logic [DATA_WIDTH-1:0] c_mem [NN];
    logic [DATA_WIDTH-1:0] r_mem [NN];

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_last = (load_cnt == LW'(3 * NN - 1));
    assign out_last  = (out_idx == EW'(NN - 1));
    assign is_comp   = (state_q == ST_COMPUTE);
    assign k_fin     = (k_cnt == KW'(MATRIX_DIM));
    assign j_last    = (j_cnt == IW'(MATRIX_DIM - 1));
    assign i_last    = (i_cnt == IW'(MATRIX_DIM - 1));
    assign comp_last = is_comp && k_fin && j_last && i_last;
    assign mac_en    = is_comp && !k_fin;
    assign mac_fin   = is_comp && k_fin;
    assign mac_clr   = (k_cnt == '0);

    // k = MATRIX_DIM is the finalize slot; park the operand index so it stays in range.
    assign k_rd  = k_fin ? '0 : k_cnt;
    assign a_idx = EW'(int'(i_cnt) * MATRIX_DIM + int'(k_rd));
    assign b_idx = EW'(int'(k_rd) * MATRIX_DIM + int'(j_cnt));
    assign c_idx = EW'(int'(i_cnt) * MATRIX_DIM + int'(j_cnt));

    assign out_data = (state_q == ST_OUT) ? r_mem[out_idx] : '0;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = irst_n;
                if (in_valid && irst_n && load_last) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (comp_last) state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && out_last) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        ld_sel = 2'd0;
        ld_idx = EW'(load_cnt);
        if (int'(load_cnt) >= 2 * NN) begin
            ld_sel = 2'd2;
            ld_idx = EW'(int'(load_cnt) - 2 * NN);
        end else if (int'(load_cnt) >= NN) begin
            ld_sel = 2'd1;
            ld_idx = EW'(int'(load_cnt) - NN);
        end
    end

    // NOTE: the matrix buffers are deliberately not reset; each job overwrites them before use.
    always_ff @(posedge iclk) begin
        if (in_fire) begin
            case (ld_sel)
                2'd0:    a_mem[ld_idx] <= in_data;
                2'd1:    b_mem[ld_idx] <= in_data;
                default: c_mem[ld_idx] <= in_data;
            endcase
        end
        if (mac_fin) r_mem[c_idx] <= mac_result;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= ST_LOAD;
            load_cnt <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            out_idx  <= '0;
            alpha_q  <= '0;
            beta_q   <= '0;
            ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                if (load_cnt == '0) begin
                    alpha_q <= alpha;
                    beta_q  <= beta;
                    ovf     <= 1'b0;
                end
                load_cnt <= load_last ? '0 : load_cnt + 1'b1;
            end
            if (is_comp) begin
                if (k_fin) begin
                    k_cnt <= '0;
                    if (j_last) begin
                        j_cnt <= '0;
                        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                end
            end
            if (mac_sat) ovf <= 1'b1;
            if (out_fire) out_idx <= out_last ? '0 : out_idx + 1'b1;
        end
    end

    gemm_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .clear    (mac_clr),
        .enable   (mac_en),
        .finalize (mac_fin),
        .a        (a_mem[a_idx]),
        .b        (b_mem[b_idx]),
        .alpha    (alpha_q),
        .beta     (beta_q),
        .c        (c_mem[c_idx]),
        .result   (mac_result),
        .sat      (mac_sat)
    );

endmodule

// File: tb/tb_gemm_stream_engine.sv
// Scoreboard bench for gemm_stream_engine: directed jobs queue expected results, a monitor checks the output stream.
module tb_gemm_stream_engine;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [DW-1:0] alpha     = '0;
    logic [DW-1:0] beta      = '0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, busy, ovf;
    logic [DW-1:0] out_data;

    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];
    logic [DW-1:0] mc [NN];
    logic [DW-1:0] mr [NN];
    logic [DW-1:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rx_cnt = 0;
    int e_cyc  = 0;

    gemm_stream_engine #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (8),
        .MATRIX_DIM (N),
        .ACC_WIDTH  (48)
    ) dut (
        .iclk      (clk),
        .irst_n    (rst_n),
        .alpha     (alpha),
        .beta      (beta),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented result against the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid) begin
            check("no_in_ready_in_out", in_ready, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected nothing", out_data);
            end else if (out_ready) begin
                check("result", out_data, exp_q[0]);
                void'(exp_q.pop_front());
                rx_cnt++;
            end else begin
                check("stalled_result", out_data, exp_q[0]);
            end
        end
    end

    task automatic push_exp();
        for (int n = 0; n < NN; n++) exp_q.push_back(mr[n]);
    endtask

    task automatic load_job(input logic [DW-1:0] al, input logic [DW-1:0] be, input bit gap);
        int n = 0;
        int t = 0;
        bit fire;
        alpha = al;
        beta  = be;
        while (n < 3 * NN && t < 1000) begin
            in_valid = !(gap && (t % 2 == 1));
            in_data  = (n < NN) ? ma[n] : (n < 2 * NN) ? mb[n - NN] : mc[n - 2 * NN];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                if (n == 0) begin
                    check("ovf_clear_first_word", ovf, 0);
                    alpha = 16'h7777;
                    beta  = 16'h7777;
                end
                n++;
            end
            t++;
        end
        in_valid = 1'b0;
        check("load_complete", n, 3 * NN);
        e_cyc = cyc;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic set_identity_job();
        for (int n = 0; n < NN; n++) begin
            ma[n] = (n / N == n % N) ? 16'd256 : 16'd0;
            mb[n] = 16'(256 * n);
            mc[n] = '0;
            mr[n] = 16'(256 * n);
        end
    endtask

    initial begin
        int base;
        int t;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;

        // Identity pass-through with latency and ignored-operand checks.
        set_identity_job();
        push_exp();
        load_job(16'd256, 16'd0, 1'b0);
        check("busy_after_last_word", busy, 1);
        check("in_ready_in_compute", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("junk_ignored", in_ready, 0);
        end
        in_valid = 1'b0;
        while (cyc < e_cyc + 79) begin
            @(posedge clk);
            #1;
        end
        check("out_valid_low_at_E79", out_valid, 0);
        @(posedge clk);
        #1;
        check("out_valid_high_at_E80", out_valid, 1);
        wait_drain("identity");
        check("identity_ovf", ovf, 0);
        check("idle_busy", busy, 0);

        // Floor rounding: p=-1, t=128*-1 + -256*256 = -65664, /256 = -256.5 -> -257.
        for (int n = 0; n < NN; n++) begin
            mb[n] = 16'hFFFF;
            mc[n] = 16'd256;
            mr[n] = 16'hFEFF;
        end
        push_exp();
        load_job(16'd128, 16'hFF00, 1'b0);
        wait_drain("floor_round");

        // Beta path: 0.5 * 2.0 = 1.0.
        for (int n = 0; n < NN; n++) begin
            mb[n] = '0;
            mc[n] = 16'd512;
            mr[n] = 16'd256;
        end
        push_exp();
        load_job(16'd256, 16'd128, 1'b0);
        wait_drain("beta");
        check("beta_ovf", ovf, 0);

        // Positive saturation.
        for (int n = 0; n < NN; n++) begin
            ma[n] = 16'h7FFF;
            mb[n] = 16'h7FFF;
            mc[n] = '0;
            mr[n] = 16'h7FFF;
        end
        push_exp();
        load_job(16'd256, 16'd0, 1'b0);
        wait_drain("sat_pos");
        check("sat_pos_ovf", ovf, 1);

        // Negative saturation; first word must clear the sticky flag before it sets again.
        for (int n = 0; n < NN; n++) begin
            ma[n] = 16'h8000;
            mr[n] = 16'h8000;
        end
        push_exp();
        load_job(16'd256, 16'd0, 1'b0);
        wait_drain("sat_neg");
        check("sat_neg_ovf", ovf, 1);

        // Backpressure: R[i][j] = 2*256*(24+4j) + 256*i with A all ones, gapped load.
        for (int n = 0; n < NN; n++) begin
            ma[n] = 16'd256;
            mb[n] = 16'(256 * n);
            mc[n] = 16'(256 * (n / N));
            mr[n] = 16'(12288 + 2048 * (n % N) + 256 * (n / N));
        end
        push_exp();
        base = rx_cnt;
        load_job(16'd512, 16'd256, 1'b1);
        t = 0;
        while (rx_cnt < base + 6 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_reached_result6", rx_cnt - base, 6);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_held_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("backpressure");
        check("bp_count", rx_cnt - base, NN);
        check("bp_ovf", ovf, 0);

        // Reset 20 cycles into a saturating job, then a clean identity job.
        for (int n = 0; n < NN; n++) begin
            ma[n] = 16'h7FFF;
            mb[n] = 16'h7FFF;
            mc[n] = '0;
        end
        load_job(16'd256, 16'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("midjob_ovf_set", ovf, 1);
        check("midjob_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_in_ready_release", in_ready, 1);
        check("mrst_busy_release", busy, 0);
        @(posedge clk);
        #1;
        set_identity_job();
        push_exp();
        load_job(16'd256, 16'd0, 1'b0);
        wait_drain("post_reset_identity");
        check("post_reset_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gemm_stream_engine.md
# gemm_stream_engine

Sequential, parametrised successor to the combinational `gemm_top`. It computes R = alpha·(A×B) + beta·C on signed fixed-point N×N matrices using a single time-shared MAC. Operands arrive over a valid/ready input stream and results leave over a valid/ready output stream. It sits between the software-fed matrix loader and the power-analysis capture logic; one MAC with handshaked streams replaces N³ parallel multipliers.

## Interface
- `DATA_WIDTH`, 16: signed element, alpha and beta width.
- `FRAC_BITS`, 8: fractional bits of every operand and result (Q-format; 1.0 = 2^FRAC_BITS).
- `MATRIX_DIM`, 4: N, for square N×N matrices; must be ≥ 2.
- `ACC_WIDTH`, 48: accumulator width; must be ≥ 2·DATA_WIDTH + clog2(MATRIX_DIM).
- `iclk`  in  1: sole clock, rising edge.
- `irst_n`  in  1: reset, asynchronous assert, active-low.
- `alpha`, `beta`  in  DATA_WIDTH: signed scale factors, sampled with the first accepted load word.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: engine accepts a word this cycle.
- `in_data`  in  DATA_WIDTH: operand word.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: consumer accepts a result this cycle.
- `out_data`  out  DATA_WIDTH: result element.
- `busy`  out  1: high in COMPUTE and OUT.
- `ovf`  out  1: sticky; set when any saturation occurred in the current job.

## Operation
- States: LOAD → COMPUTE → OUT → LOAD. Reset enters LOAD.
- **LOAD**
  - `in_ready`=1. Accepts exactly 3·N² words on `in_valid && in_ready`, in order: A, then B, then C, each row-major.
  - First accepted word of the job latches alpha and beta, and clears `ovf`.
  - The last word moves the state to COMPUTE.
- **COMPUTE**
  - `in_ready`=0. For each (i,j) in row-major order, N MAC cycles compute acc += A[i][k]·B[k][j] for k = 0..N-1; acc is cleared at k=0.
  - One finalize cycle follows, then R[i][j] is written.
  - Total: N²·(N+1) cycles.
- **Finalize arithmetic**
  - p = sat_DW(acc >>> FRAC_BITS).
  - t = alpha·p + beta·C[i][j], in 2·DATA_WIDTH+1 bits.
  - R = sat_DW(t >>> FRAC_BITS).
  - Shifts are arithmetic (truncate toward −inf).
  - sat_DW clamps to [−2^(DW−1), 2^(DW−1)−1]. Either clamp activating sets `ovf`.
- **OUT**
  - `out_valid`=1, `out_data`=R[idx]. idx advances on `out_valid && out_ready`.
  - The N²th transfer returns the state to LOAD.
  - `out_data` is held stable while `out_ready`=0.
- **Input gating:** input words presented outside LOAD are ignored (`in_ready`=0). They are not buffered.

## Timing
- Reset values: `in_ready`=0 while `irst_n`=0, then 1 from the first cycle after release. `out_valid`=0, `out_data`=0, `busy`=0, `ovf`=0. All counters are 0.
- If the last operand is accepted at edge E, `out_valid` rises immediately after edge E + N²·(N+1). For N=4 that is E+80.
- Throughput: one result per cycle when `out_ready`=1. Minimum job period is 3N² + N²(N+1) + N² cycles.
- `in_ready` and `out_valid` are pure state decodes and are never both high. `busy` = (state ≠ LOAD).
- `in_valid` low mid-load stalls the load counter with no timeout.
- Reset mid-operation, in any state: asynchronously forces LOAD, zeroes counters, and clears `ovf` and `out_valid`. A partial job is discarded. Buffer contents need not be cleared.
- `out_ready` held high in LOAD or COMPUTE has no effect.

## Structure
- Package `gemm_pkg`:
  - state enum (`ST_LOAD`, `ST_COMPUTE`, `ST_OUT`)
  - the `sat_dw` function
  - index-width localparams from clog2(MATRIX_DIM)
- Sub-module `gemm_mac`:
  - multiplier, accumulator, and finalize/saturation datapath
  - ports: clear, enable, finalize strobe, operands, alpha, beta, C element
  - outputs: result and a saturation flag
- Top level holds the FSM, A/B/C/R register arrays, and the load, i/j/k and output counters.

## Test plan
- **Identity pass-through:** A = 256·I, B[i][j] = 256·(4i+j), C = 0, alpha = 256, beta = 0 → R = B exactly; `ovf`=0.
- **Beta path:** A = 256·I, B = 0, C = 512 everywhere, alpha = 256, beta = 128 (0.5) → all 16 results = 256.
- **Saturation:** C = 0, beta = 0, alpha = 256.
  - A = B = 32767 everywhere → all R = 32767, `ovf`=1.
  - A = −32768, B = 32767 everywhere → all R = −32768.
  - Next clean job → `ovf` clears on its first accepted word.
- **Backpressure:** `out_ready` low for 5 cycles after result 6, and `in_valid` toggled every other cycle during load → 16 results in order, no loss or duplication, `out_data` stable while stalled, result unchanged.
- **Latency:** last operand accepted at edge E → `out_valid` first high after edge E+80, `busy` high from E+1. Operands driven during COMPUTE are ignored.
- **Reset mid-job:** `irst_n` pulsed low 20 cycles into COMPUTE → all outputs at reset values, state LOAD. A fresh identity job then produces correct results.
